// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe.
// Upstream request : in_valid, in_ready, instr[31:0], src[2:0]
// Downstream result: out_valid, out_ready, imm[XLEN-1:0], fmt[2:0], illegal
// Handshake rule: a beat moves on a rising edge exactly when valid && ready
// are both high at that edge.
// The source keeps a beat stable while its valid is high and ready is low.
// The 'master' modport is the side that issues requests and takes results.
// The 'slave' modport is the immediate generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;

    modport master (
        output in_valid, instr, src, out_ready,
        input  in_ready, out_valid, imm, fmt, illegal
    );

    modport slave (
        input  in_valid, instr, src, out_ready,
        output in_ready, out_valid, imm, fmt, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a two-entry registered output (OUT + SKID).
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - imm_gen_pipe_if.slave
//           request : in_valid/in_ready, instr, src
//           result  : out_valid/out_ready, imm, fmt, illegal
// Parameters:
//   XLEN     - immediate width, 32 or 64
//   AUTO_FMT - 0: format comes from src, 1: format decoded from instr[6:0]
// Every output comes from a flop.
// in_ready is the inverse of the skid-valid flop, so it never depends
// combinationally on out_ready.
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int AUTO_FMT = 0
) (
    input  logic          clk,
    input  logic          reset,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_S   = 3'b001;
    localparam logic [2:0] FMT_B   = 3'b010;
    localparam logic [2:0] FMT_J   = 3'b011;
    localparam logic [2:0] FMT_U   = 3'b100;
    localparam logic [2:0] FMT_BAD = 3'b111;

    // Combinational result for the request currently on the bus
    logic [2:0]      dec_fmt;
    logic [2:0]      sel_fmt;
    logic [31:0]     raw;
    logic [XLEN-1:0] res_imm;
    logic [2:0]      res_fmt;
    logic            res_ill;

    always_comb begin
        case (bus.instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
            7'b0100011:                                     dec_fmt = FMT_S;
            7'b1100011:                                     dec_fmt = FMT_B;
            7'b0110111, 7'b0010111:                         dec_fmt = FMT_U;
            7'b1101111:                                     dec_fmt = FMT_J;
            default:                                        dec_fmt = FMT_BAD;
        endcase

        sel_fmt = (AUTO_FMT != 0) ? dec_fmt : bus.src;
        raw     = '0;
        res_fmt = sel_fmt;
        res_ill = 1'b0;

        // Every field is first built as a 32-bit signed value.
        // The final cast then widens it from instr[31] to XLEN bits.
        case (sel_fmt)
            FMT_I: raw = {{20{bus.instr[31]}}, bus.instr[31:20]};
            FMT_S: raw = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            FMT_B: raw = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                          bus.instr[30:25], bus.instr[11:8], 1'b0};
            FMT_J: raw = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                          bus.instr[20], bus.instr[30:21], 1'b0};
            FMT_U: raw = {bus.instr[31:12], 12'b0};
            default: begin
                raw     = '0;
                res_fmt = FMT_BAD;
                res_ill = 1'b1;
            end
        endcase

        res_imm = XLEN'($signed(raw));
    end

    // Storage: OUT drives the result port, SKID absorbs one beat of backpressure
    logic            out_v;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_ill;
    logic            skid_v;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            skid_ill;

    logic take_in;
    logic take_out;

    assign take_in  = bus.in_valid && !skid_v;
    assign take_out = out_v && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_v    <= 1'b0;
            out_imm  <= '0;
            out_fmt  <= '0;
            out_ill  <= 1'b0;
            skid_v   <= 1'b0;
            skid_imm <= '0;
            skid_fmt <= '0;
            skid_ill <= 1'b0;
        end else if (take_out || !out_v) begin
            // OUT is free after this edge.
            // A waiting skid beat is older than any new request, so it goes first.
            // While SKID is full, take_in is low.
            if (skid_v) begin
                out_v   <= 1'b1;
                out_imm <= skid_imm;
                out_fmt <= skid_fmt;
                out_ill <= skid_ill;
                skid_v  <= 1'b0;
            end else if (take_in) begin
                out_v   <= 1'b1;
                out_imm <= res_imm;
                out_fmt <= res_fmt;
                out_ill <= res_ill;
            end else begin
                out_v   <= 1'b0;
            end
        end else if (take_in) begin
            // OUT is stalled and SKID is empty (take_in implies it), so park the beat
            skid_v   <= 1'b1;
            skid_imm <= res_imm;
            skid_fmt <= res_fmt;
            skid_ill <= res_ill;
        end
    end

    assign bus.in_ready  = !skid_v;
    assign bus.out_valid = out_v;
    assign bus.imm       = out_imm;
    assign bus.fmt       = out_fmt;
    assign bus.illegal   = out_ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe.
// Two instances are exercised:
//   u32 - XLEN=32, format taken from src
//   u64 - XLEN=64, format decoded from the opcode
// Expected results are packed as {illegal, fmt, imm[63:0]}.
// A 32-bit result is zero-padded in the upper imm bits.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    imm_gen_pipe #(.XLEN(32), .AUTO_FMT(0)) u32 (.clk(clk), .reset(rst), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(64), .AUTO_FMT(1)) u64 (.clk(clk), .reset(rst), .bus(b64.slave));

    int total  = 0;
    int passed = 0;
    logic [67:0] exp32_q[$];
    logic [67:0] exp64_q[$];

    // Independent reference for the immediate formats
    function automatic logic [67:0] model(input logic [31:0] ins, input logic [2:0] s,
                                          input bit auto_fmt, input bit is32);
        logic [2:0]  f;
        logic [63:0] v;
        f = s;
        if (auto_fmt) begin
            case (ins[6:0])
                7'h13, 7'h03, 7'h67, 7'h73: f = 3'd0;
                7'h23:                      f = 3'd1;
                7'h63:                      f = 3'd2;
                7'h6F:                      f = 3'd3;
                7'h37, 7'h17:               f = 3'd4;
                default:                    f = 3'd7;
            endcase
        end
        case (f)
            3'd0: v = {{52{ins[31]}}, ins[31:20]};
            3'd1: v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2: v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd4: v = {{32{ins[31]}}, ins[31:12], 12'b0};
            default: return {1'b1, 3'b111, 64'd0};
        endcase
        if (is32) v[63:32] = 32'd0;
        return {1'b0, f, v};
    endfunction

    // Driver: called at a falling edge.
    // It applies inputs and notes whether the coming rising edge delivers a
    // result (sampled now).
    // If the request is accepted, expv is pushed.
    // It returns at the next falling edge.
    task automatic drive32(input logic v, input logic [31:0] ins, input logic [2:0] s,
                           input logic ordy, input logic [67:0] expv,
                           output logic del, output logic [67:0] obs);
        b32.in_valid  = v;
        b32.instr     = ins;
        b32.src       = s;
        b32.out_ready = ordy;
        del = b32.out_valid && ordy && !rst;
        obs = {b32.illegal, b32.fmt, 32'd0, b32.imm};
        if (v && b32.in_ready && !rst) exp32_q.push_back(expv);
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
    endtask

    task automatic drive64(input logic v, input logic [31:0] ins, input logic ordy,
                           input logic [67:0] expv,
                           output logic del, output logic [67:0] obs);
        b64.in_valid  = v;
        b64.instr     = ins;
        b64.src       = 3'd0;
        b64.out_ready = ordy;
        del = b64.out_valid && ordy && !rst;
        obs = {b64.illegal, b64.fmt, b64.imm};
        if (v && b64.in_ready && !rst) exp64_q.push_back(expv);
        @(posedge clk);
        @(negedge clk);
        b64.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({b32.out_valid, b32.in_ready} !== 2'b01)
            $display("FAIL reset_hs32 got v/r=%b%b exp 01", b32.out_valid, b32.in_ready);
        else passed++;
        total++;
        if ({b32.illegal, b32.fmt, b32.imm} !== 36'd0)
            $display("FAIL reset_data32 got ill=%b fmt=%b imm=%h exp 0", b32.illegal, b32.fmt, b32.imm);
        else passed++;
        total++;
        if ({b64.out_valid, b64.in_ready, b64.illegal, b64.fmt, b64.imm} !== {2'b01, 68'd0})
            $display("FAIL reset64 got v=%b r=%b ill=%b fmt=%b imm=%h", b64.out_valid,
                     b64.in_ready, b64.illegal, b64.fmt, b64.imm);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_i_format();
        logic del;
        logic [67:0] obs, e;
        drive32(1'b1, 32'hFFF00093, 3'b000, 1'b1, {1'b0, 3'b000, 32'd0, 32'hFFFFFFFF}, del, obs);
        total++;
        if (b32.out_valid !== 1'b1 || b32.imm !== 32'hFFFFFFFF || b32.fmt !== 3'b000)
            $display("FAIL i_latency got v=%b imm=%h fmt=%b exp 1 ffffffff 000",
                     b32.out_valid, b32.imm, b32.fmt);
        else passed++;
        drive32(1'b0, 32'd0, 3'd0, 1'b1, 68'd0, del, obs);
        total++;
        if (!del || exp32_q.size() == 0) $display("FAIL i_deliver got del=%b exp 1", del);
        else begin
            e = exp32_q.pop_front();
            if (obs !== e) $display("FAIL i_sb got %h exp %h", obs, e);
            else passed++;
        end
    endtask

    // Back-to-back S, B, J requests, then illegal src codes, at full rate
    task automatic test_back_to_back();
        logic [31:0] ins [6];
        logic [2:0]  srcs[6];
        logic [67:0] exps[6];
        logic del;
        logic [67:0] obs, e;
        int n_del;
        ins[0] = 32'hFE20AE23; srcs[0] = 3'b001; exps[0] = {1'b0, 3'b001, 32'd0, 32'hFFFFFFFC};
        ins[1] = 32'hFE000CE3; srcs[1] = 3'b010; exps[1] = {1'b0, 3'b010, 32'd0, 32'hFFFFFFF8};
        ins[2] = 32'h0010006F; srcs[2] = 3'b011; exps[2] = {1'b0, 3'b011, 32'd0, 32'h00000800};
        ins[3] = 32'hFFF00093; srcs[3] = 3'b101; exps[3] = {1'b1, 3'b111, 64'd0};
        ins[4] = 32'h800000B7; srcs[4] = 3'b110; exps[4] = {1'b1, 3'b111, 64'd0};
        ins[5] = 32'h12345678; srcs[5] = 3'b111; exps[5] = {1'b1, 3'b111, 64'd0};
        n_del = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) drive32(1'b1, ins[k], srcs[k], 1'b1, exps[k], del, obs);
            else       drive32(1'b0, 32'd0, 3'd0, 1'b1, 68'd0, del, obs);
            if (del) begin
                n_del++;
                total++;
                if (exp32_q.size() == 0) $display("FAIL b2b_extra got %h exp none", obs);
                else begin
                    e = exp32_q.pop_front();
                    if (obs !== e) $display("FAIL b2b_sb got %h exp %h", obs, e);
                    else passed++;
                end
            end
        end
        total++;
        if (n_del !== 6) $display("FAIL b2b_count got %0d exp 6", n_del);
        else passed++;
    endtask

    task automatic test_auto64();
        logic [6:0]  ops[13];
        logic [31:0] ins;
        logic del;
        logic [67:0] obs, e;
        int n;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                7'h33, 7'h0F, 7'h7F, 7'h00};
        n = 0;
        for (int k = 0; k < 17; k++) begin
            if (k == 0) drive64(1'b1, 32'h800000B7, 1'b1, {1'b0, 3'b100, 64'hFFFFFFFF80000000}, del, obs);
            else if (k == 1) drive64(1'b1, 32'h00000033, 1'b1, {1'b1, 3'b111, 64'd0}, del, obs);
            else if (k < 15) begin
                ins = $urandom;
                ins[6:0] = ops[k-2];
                drive64(1'b1, ins, 1'b1, model(ins, 3'd0, 1'b1, 1'b0), del, obs);
            end else drive64(1'b0, 32'd0, 1'b1, 68'd0, del, obs);
            if (del) begin
                n++;
                total++;
                if (exp64_q.size() == 0) $display("FAIL auto64_extra got %h exp none", obs);
                else begin
                    e = exp64_q.pop_front();
                    if (obs !== e) $display("FAIL auto64_sb got %h exp %h", obs, e);
                    else passed++;
                end
            end
        end
        total++;
        if (n !== 15) $display("FAIL auto64_count got %0d exp 15", n);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic del;
        logic [67:0] obs, e;
        logic [67:0] ea, eb;
        ea = {1'b0, 3'b000, 32'd0, 32'h00000123};
        eb = {1'b0, 3'b001, 32'd0, 32'hFFFFFFFC};
        drive32(1'b1, 32'h12300093, 3'b000, 1'b0, ea, del, obs);
        drive32(1'b1, 32'hFE20AE23, 3'b001, 1'b0, eb, del, obs);
        total++;
        if (b32.in_ready !== 1'b0) $display("FAIL bp_full got in_ready=%b exp 0", b32.in_ready);
        else passed++;
        // Request offered while in_ready=0 must be ignored
        drive32(1'b1, 32'h0010006F, 3'b011, 1'b0, 68'd0, del, obs);
        total++;
        if ({b32.out_valid, b32.illegal, b32.fmt, b32.imm} !== {1'b1, ea[67:64], ea[31:0]})
            $display("FAIL bp_hold got v=%b imm=%h fmt=%b exp 1 %h", b32.out_valid, b32.imm,
                     b32.fmt, ea[31:0]);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            drive32(1'b0, 32'd0, 3'd0, 1'b1, 68'd0, del, obs);
            total++;
            if (!del || exp32_q.size() == 0) $display("FAIL bp_deliver%0d got del=%b exp 1", k, del);
            else begin
                e = exp32_q.pop_front();
                if (obs !== e) $display("FAIL bp_order%0d got %h exp %h", k, obs, e);
                else passed++;
            end
            if (k == 0) begin
                total++;
                if (b32.in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", b32.in_ready);
                else passed++;
            end
        end
        total++;
        if (b32.out_valid !== 1'b0) $display("FAIL bp_empty got out_valid=%b exp 0", b32.out_valid);
        else passed++;
    endtask

    task automatic test_random();
        logic del;
        logic [67:0] obs, e;
        logic [31:0] ins;
        logic [2:0]  s;
        logic [6:0]  ops[9];
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        for (int k = 0; k < 220; k++) begin
            ins = $urandom;
            s   = 3'($urandom_range(0, 7));
            if (k < 200) drive32(1'($urandom_range(0, 1)), ins, s, 1'($urandom_range(0, 1)),
                                 model(ins, s, 1'b0, 1'b1), del, obs);
            else         drive32(1'b0, 32'd0, 3'd0, 1'b1, 68'd0, del, obs);
            if (del) begin
                total++;
                if (exp32_q.size() == 0) $display("FAIL rnd32_extra got %h exp none", obs);
                else begin
                    e = exp32_q.pop_front();
                    if (obs !== e) $display("FAIL rnd32_sb got %h exp %h", obs, e);
                    else passed++;
                end
            end
        end
        for (int k = 0; k < 220; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[6:0] = ops[$urandom_range(0, 8)];
            if (k < 200) drive64(1'($urandom_range(0, 1)), ins, 1'($urandom_range(0, 1)),
                                 model(ins, 3'd0, 1'b1, 1'b0), del, obs);
            else         drive64(1'b0, 32'd0, 1'b1, 68'd0, del, obs);
            if (del) begin
                total++;
                if (exp64_q.size() == 0) $display("FAIL rnd64_extra got %h exp none", obs);
                else begin
                    e = exp64_q.pop_front();
                    if (obs !== e) $display("FAIL rnd64_sb got %h exp %h", obs, e);
                    else passed++;
                end
            end
        end
        total++;
        if (exp32_q.size() != 0 || exp64_q.size() != 0)
            $display("FAIL rnd_drain got %0d/%0d left exp 0/0", exp32_q.size(), exp64_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic del;
        logic [67:0] obs, e;
        int stray;
        drive32(1'b1, 32'h00100093, 3'b000, 1'b0, {1'b0, 3'b000, 32'd0, 32'd1}, del, obs);
        drive32(1'b1, 32'h00200093, 3'b000, 1'b0, {1'b0, 3'b000, 32'd0, 32'd2}, del, obs);
        rst = 1'b1;
        drive32(1'b1, 32'h00300093, 3'b000, 1'b1, 68'd0, del, obs);
        total++;
        if ({b32.out_valid, b32.in_ready} !== 2'b01)
            $display("FAIL rst_mid got v/r=%b%b exp 01", b32.out_valid, b32.in_ready);
        else passed++;
        exp32_q.delete();
        rst = 1'b0;
        // First edge after reset must accept
        drive32(1'b1, 32'hFFC00093, 3'b000, 1'b1, {1'b0, 3'b000, 32'd0, 32'hFFFFFFFC}, del, obs);
        total++;
        if (b32.out_valid !== 1'b1 || b32.imm !== 32'hFFFFFFFC)
            $display("FAIL rst_accept got v=%b imm=%h exp 1 fffffffc", b32.out_valid, b32.imm);
        else passed++;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            drive32(1'b0, 32'd0, 3'd0, 1'b1, 68'd0, del, obs);
            if (del) begin
                if (exp32_q.size() == 0) stray++;
                else begin
                    e = exp32_q.pop_front();
                    total++;
                    if (obs !== e) $display("FAIL rst_post_sb got %h exp %h", obs, e);
                    else passed++;
                end
            end
        end
        total++;
        if (stray != 0 || exp32_q.size() != 0)
            $display("FAIL rst_stray got %0d extra, %0d missing exp 0", stray, exp32_q.size());
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        b32.in_valid = 1'b0; b32.instr = '0; b32.src = '0; b32.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.instr = '0; b64.src = '0; b64.out_ready = 1'b0;
        test_reset();
        test_i_format();
        test_back_to_back();
        test_auto64();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
